// File: rtl/grid_plot_scheduler.sv
// grid_plot_scheduler: sole driver of the vga_adapter plot port for the 28x28 cell grid.
// Queued single-cell redraws and full-grid repaints are expanded into 4x4 pixel blocks.
// Optional build macro: GRID_PLOT_COALESCE_EN (merge a request into a matching FIFO tail entry).
module grid_plot_scheduler #(
  parameter int GRID_SIZE  = 28,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       cell_req,
  input  logic [4:0] cell_x,
  input  logic [4:0] cell_y,
  input  logic [2:0] cell_colour,
  output logic       cell_ready,
  input  logic       full_req,
  output logic [4:0] rd_x,
  output logic [4:0] rd_y,
  input  logic [2:0] rd_colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       drop_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [4:0]    LAST    = 5'(GRID_SIZE - 1);
  localparam logic [4:0]    GRID_C  = 5'(GRID_SIZE);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PAINT} state_t;

  state_t state, state_n;

  // FIFO storage: {x[4:0], y[4:0], colour[2:0]}
  logic [12:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [12:0]   head;

  logic in_range, accept, push, pop, flush, coal_hit;
  logic pending, clr_pending;

  // Current paint cell (queued cell or repaint counter), its colour, offsets, mode
  logic [4:0] px, py, px_n, py_n;
  logic [2:0] pcol, pcol_n;
  logic [1:0] ox, oy, ox_n, oy_n;
  logic       mode, mode_n;   // 1 = full repaint, 0 = queued cell

  assign head     = mem[rd_ptr];
  assign in_range = (cell_x < GRID_C) && (cell_y < GRID_C);

`ifdef GRID_PLOT_COALESCE_EN
  logic [PW-1:0] tail_ptr;
  logic [12:0]   tail;
  assign tail_ptr = wr_ptr - 1'b1;
  assign tail     = mem[tail_ptr];
  // A tail entry that is leaving (popped as the only entry, or flushed) cannot absorb a request
  assign coal_hit = in_range && (count != '0) && (tail[12:8] == cell_x) &&
                    (tail[7:3] == cell_y) && !(pop && (count == CW'(1))) && !flush;
`else
  assign coal_hit = 1'b0;
`endif

  assign cell_ready = (count < DEPTH_C) || coal_hit;
  assign accept     = cell_req && cell_ready;
  assign push       = accept && in_range && !coal_hit;
  assign busy       = (state != IDLE) || (count != '0) || pending;

  // FIFO entry storage; coalescing rewrites only the colour field of the tail
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem[wr_ptr] <= {cell_x, cell_y, cell_colour};
    end
`ifdef GRID_PLOT_COALESCE_EN
    else if (accept && coal_hit) begin
      mem[tail_ptr][2:0] <= cell_colour;
    end
`endif
  end

  // FIFO pointers and occupancy; a flush discards old entries but keeps a same-cycle push
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= CW'(push);
      end else begin
        rd_ptr <= rd_ptr + PW'(pop);
        count  <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Repaint request flag and sticky drop error
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pending  <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      pending  <= full_req || (pending && !clr_pending);
      drop_err <= drop_err || (accept && !in_range);
    end
  end

  // Next-state logic, FIFO pop/flush decisions and paint-cell sequencing
  always_comb begin
    state_n     = state;
    px_n        = px;
    py_n        = py;
    pcol_n      = pcol;
    ox_n        = ox;
    oy_n        = oy;
    mode_n      = mode;
    pop         = 1'b0;
    flush       = 1'b0;
    clr_pending = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending) begin
          clr_pending = 1'b1;
          flush       = 1'b1;
          px_n        = '0;
          py_n        = '0;
          mode_n      = 1'b1;
          state_n     = FETCH;
        end else if (count != '0) begin
          pop     = 1'b1;
          px_n    = head[12:8];
          py_n    = head[7:3];
          pcol_n  = head[2:0];
          ox_n    = '0;
          oy_n    = '0;
          mode_n  = 1'b0;
          state_n = PAINT;
        end
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        pcol_n  = rd_colour;
        ox_n    = '0;
        oy_n    = '0;
        state_n = PAINT;
      end
      PAINT: begin
        if (ox == 2'd3 && oy == 2'd3) begin
          if (!mode || (px == LAST && py == LAST)) begin
            state_n = IDLE;
          end else begin
            if (px == LAST) begin
              px_n = '0;
              py_n = py + 5'd1;
            end else begin
              px_n = px + 5'd1;
            end
            state_n = FETCH;
          end
        end else begin
          ox_n = ox + 2'd1;
          if (ox == 2'd3) oy_n = oy + 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and paint-cell registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      px    <= '0;
      py    <= '0;
      pcol  <= '0;
      ox    <= '0;
      oy    <= '0;
      mode  <= 1'b0;
    end else begin
      state <= state_n;
      px    <= px_n;
      py    <= py_n;
      pcol  <= pcol_n;
      ox    <= ox_n;
      oy    <= oy_n;
      mode  <= mode_n;
    end
  end

  // Registered plot/lookup outputs built from next-state values so they align with the state
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      rd_x       <= '0;
      rd_y       <= '0;
    end else begin
      vga_plot <= (state_n == PAINT);
      if (state_n == PAINT) begin
        vga_x      <= {1'b0, px_n, ox_n};
        vga_y      <= {py_n, oy_n};
        vga_colour <= pcol_n;
      end
      if (state_n == FETCH) begin
        rd_x <= px_n;
        rd_y <= py_n;
      end
    end
  end

endmodule
